// File: rtl/next_state_sequencer.sv
// rtl/next_state_sequencer.sv - microsequencer: next microstore address select with moc watchdog
module next_state_sequencer #(
  parameter int                 STATE_W     = 10,
  parameter int                 MOC_TIMEOUT = 15,
  parameter logic [STATE_W-1:0] ERR_STATE   = 10'd2,
  parameter logic [STATE_W-1:0] FETCH_STATE = 10'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         N,
  input  logic               inv,
  input  logic [STATE_W-1:0] cr,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               cond,
  input  logic               moc,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] incr_state,
  output logic [7:0]         wait_cnt,
  output logic               bus_error
);

  localparam logic [2:0] N_DISPATCH = 3'b000;
  localparam logic [2:0] N_FETCH    = 3'b001;
  localparam logic [2:0] N_JUMP     = 3'b010;
  localparam logic [2:0] N_BRANCH   = 3'b011;
  localparam logic [2:0] N_SEQ      = 3'b100;
  localparam logic [2:0] N_WAIT     = 3'b101;
  localparam logic [2:0] N_CJUMP    = 3'b110;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MOC_TIMEOUT - 1);

  logic               t;
  logic               m;
  logic               waiting;
  logic               trap;
  logic [STATE_W-1:0] mux_state;
  logic [STATE_W-1:0] next_state;

  assign t       = cond ^ inv;
  assign m       = moc ^ inv;
  assign waiting = (N == N_WAIT) && !m;
  // A completing moc makes the cycle non-waiting, so it always beats the trap.
  assign trap    = waiting && (wait_cnt == TIMEOUT_LAST);

  always_comb begin
    mux_state = FETCH_STATE;
    case (N)
      N_DISPATCH: mux_state = enc_state;
      N_FETCH:    mux_state = FETCH_STATE;
      N_JUMP:     mux_state = cr;
      N_BRANCH:   mux_state = t ? cr : incr_state;
      N_SEQ:      mux_state = incr_state;
      N_WAIT:     mux_state = m ? incr_state : state;
      N_CJUMP:    mux_state = t ? cr : enc_state;
      default:    mux_state = FETCH_STATE;
    endcase
    next_state = trap ? ERR_STATE : mux_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH_STATE;
      incr_state <= FETCH_STATE + STATE_W'(1);
      wait_cnt   <= 8'd0;
      bus_error  <= 1'b0;
    end else begin
      state      <= next_state;
      incr_state <= next_state + STATE_W'(1);
      if (trap) begin
        wait_cnt  <= 8'd0;
        bus_error <= 1'b1;
      end else if (waiting) begin
        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_next_state_sequencer.sv
// tb/tb_next_state_sequencer.sv - directed-vector bench for next_state_sequencer
module tb_next_state_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] N;
  logic       inv;
  logic [9:0] cr;
  logic [9:0] enc_state;
  logic       cond;
  logic       moc;
  logic [9:0] state;
  logic [9:0] incr_state;
  logic [7:0] wait_cnt;
  logic       bus_error;

  int n_checks = 0;
  int n_pass   = 0;

  next_state_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .N          (N),
    .inv        (inv),
    .cr         (cr),
    .enc_state  (enc_state),
    .cond       (cond),
    .moc        (moc),
    .state      (state),
    .incr_state (incr_state),
    .wait_cnt   (wait_cnt),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [9:0] addr);
    N  = 3'b010;
    cr = addr;
    step();
  endtask

  task automatic check_all(input string tag, input logic [9:0] s, input logic [7:0] w, input logic be);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".incr"}, 32'(incr_state), 32'(s + 10'd1));
    check({tag, ".wait"}, 32'(wait_cnt), 32'(w));
    check({tag, ".berr"}, 32'(bus_error), 32'(be));
  endtask

  initial begin
    reset_n = 1'b0; N = 3'b100; inv = 1'b0; cr = '0; enc_state = '0; cond = 1'b0; moc = 1'b0;
    #12;
    check_all("reset", 10'h000, 8'd0, 1'b0);
    step();
    reset_n = 1'b1;

    jump(10'h155);
    check_all("jump", 10'h155, 8'd0, 1'b0);
    N = 3'b000; enc_state = 10'h040; step();
    check_all("dispatch", 10'h040, 8'd0, 1'b0);

    jump(10'h010);
    N = 3'b011; cr = 10'h0A0; cond = 1'b1; inv = 1'b0; step();
    check("branch_taken", 32'(state), 32'h0A0);
    jump(10'h010);
    N = 3'b011; cr = 10'h0A0; cond = 1'b1; inv = 1'b1; step();
    check_all("branch_inv", 10'h011, 8'd0, 1'b0);
    inv = 1'b0; cond = 1'b0;

    N = 3'b110; cr = 10'h123; enc_state = 10'h077; cond = 1'b1; step();
    check("cjump_taken", 32'(state), 32'h123);
    cond = 1'b0; step();
    check("cjump_dispatch", 32'(state), 32'h077);

    jump(10'h020);
    N = 3'b101; inv = 1'b0; moc = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_all($sformatf("wait%0d", i), 10'h020, 8'(i), 1'b0);
    end
    moc = 1'b1; step();
    check_all("wait_done", 10'h021, 8'd0, 1'b0);

    N = 3'b101; inv = 1'b1; moc = 1'b1; step();
    check_all("wait_inv", 10'h021, 8'd1, 1'b0);
    moc = 1'b0; step();
    check_all("wait_inv_done", 10'h022, 8'd0, 1'b0);
    inv = 1'b0;

    jump(10'h030);
    N = 3'b101; moc = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check_all("pre_trap", 10'h030, 8'd14, 1'b0);
    moc = 1'b1; step();
    check_all("moc_at_timeout", 10'h031, 8'd0, 1'b0);

    jump(10'h030);
    N = 3'b101; moc = 1'b0;
    for (int i = 0; i < 14; i++) step();
    step();
    check_all("trap", 10'h002, 8'd0, 1'b1);
    N = 3'b100; step();
    check_all("sticky", 10'h003, 8'd0, 1'b1);

    reset_n = 1'b0; #2;
    check_all("reset_mid", 10'h000, 8'd0, 1'b0);
    step();
    reset_n = 1'b1;

    jump(10'h050);
    N = 3'b101; moc = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midwait_cnt", 32'(wait_cnt), 32'd5);
    reset_n = 1'b0; #2;
    check_all("reset_midwait", 10'h000, 8'd0, 1'b0);
    step();
    reset_n = 1'b1;

    jump(10'h3FF);
    N = 3'b100; step();
    check_all("wrap", 10'h000, 8'd0, 1'b0);
    check("wrap_incr_raw", 32'(incr_state), 32'h001);
    jump(10'h055);
    N = 3'b111; step();
    check("reserved_fetch", 32'(state), 32'h000);
    jump(10'h066);
    N = 3'b001; step();
    check("fetch", 32'(state), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
